// File: rtl/keypad_pkg.sv
// Shared keypad definitions: column drive patterns, the "no key" candidate
// encoding, scan FSM state codes and the matrix position to key code map.
package keypad_pkg;

  // Candidate is {none_flag, code}; bit 4 set means no key in the sweep.
  localparam logic [4:0] CAND_NONE = 5'b1_0000;

  // Scan FSM states.
  localparam logic [0:0] ST_SCAN = 1'b0;
  localparam logic [0:0] ST_EVAL = 1'b1;

  // Active-low one-hot drive for a column index.
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    case (idx)
      2'd0:    return 4'b1110;
      2'd1:    return 4'b1101;
      2'd2:    return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  // Key legend printed on the keypad, indexed by (column, row).
  function automatic logic [3:0] key_map(input logic [1:0] col, input logic [1:0] row);
    case ({col, row})
      4'h0:    return 4'h1;
      4'h1:    return 4'h4;
      4'h2:    return 4'h7;
      4'h3:    return 4'h0;
      4'h4:    return 4'h2;
      4'h5:    return 4'h5;
      4'h6:    return 4'h8;
      4'h7:    return 4'hF;
      4'h8:    return 4'h3;
      4'h9:    return 4'h6;
      4'hA:    return 4'h9;
      4'hB:    return 4'hE;
      4'hC:    return 4'hA;
      4'hD:    return 4'hB;
      4'hE:    return 4'hC;
      default: return 4'hD;
    endcase
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Sweep-rate debouncer: accepts a per-sweep candidate and only changes the
// debounced key state after DEBOUNCE_SCANS identical sweeps. A change from
// no key to a key emits a one-cycle press pulse carrying the key code.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4,
  parameter int CNT_W          = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       eval_vld,
  input  logic       cand_ghost,
  input  logic [4:0] cand,
  output logic       held,
  output logic       press_vld,
  output logic [3:0] press_code
);

  localparam logic [CNT_W-1:0] MATCH_TERM = CNT_W'(DEBOUNCE_SCANS);

  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] match_nxt;
  logic [4:0]       prev_cand;
  logic             prev_vld;
  logic [4:0]       db_state;

  // Match counter increment that sticks at the acceptance threshold.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= MATCH_TERM) ? MATCH_TERM : v + 1'b1;
  endfunction

  // Match count this sweep would produce; a fresh or differing candidate starts at 1.
  always_comb begin
    match_nxt = CNT_W'(1);
    if (prev_vld && (cand == prev_cand)) match_nxt = sat_inc(match_cnt);
  end

  // Per-sweep debounce state update and press pulse generation.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      match_cnt  <= '0;
      prev_cand  <= CAND_NONE;
      prev_vld   <= 1'b0;
      db_state   <= CAND_NONE;
      press_vld  <= 1'b0;
      press_code <= 4'h0;
    end else begin
      press_vld <= 1'b0;
      if (eval_vld) begin
        if (cand_ghost) begin
          // Ambiguous sweep breaks any run of matches.
          match_cnt <= '0;
          prev_vld  <= 1'b0;
        end else begin
          match_cnt <= match_nxt;
          prev_cand <= cand;
          prev_vld  <= 1'b1;
          if ((match_nxt == MATCH_TERM) && (cand != db_state)) begin
            if (db_state[4]) begin
              db_state   <= cand;
              press_vld  <= 1'b1;
              press_code <= cand[3:0];
            end else if (cand[4]) begin
              db_state <= CAND_NONE;
            end
            // Key-to-different-key without a release is ignored.
          end
        end
      end
    end
  end

  assign held = ~db_state[4];

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: drives one active-low column at a time, samples the
// synchronized rows after a settle time, classifies each full sweep,
// debounces it and presents accepted presses to the CPU as a held interrupt.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int CNT_W          = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] Row,
  output logic [3:0] Col,
  output logic [3:0] KeyCode,
  output logic       KeyIrq,
  input  logic       IntAck,
  output logic       Overrun,
  output logic       KeyHeld
);

  localparam logic [CNT_W-1:0] SETTLE_TERM = CNT_W'(SETTLE_CYCLES - 1);

  logic [3:0]       row_sync_p0;
  logic [3:0]       row_sync_p1;
  logic [0:0]       state;
  logic [1:0]       col_idx;
  logic [CNT_W-1:0] settle_cnt;
  logic [15:0]      sweep_img;
  logic [4:0]       zero_cnt;
  logic [3:0]       zero_pos;
  logic [4:0]       cand;
  logic             cand_ghost;
  logic             eval_vld;
  logic             press_vld;
  logic [3:0]       press_code;

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      row_sync_p0 <= 4'hF;
      row_sync_p1 <= 4'hF;
    end else begin
      row_sync_p0 <= Row;
      row_sync_p1 <= row_sync_p0;
    end
  end

  // Scan FSM: settle each column, capture its rows, then one EVAL cycle per sweep.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= ST_SCAN;
      col_idx    <= 2'd0;
      settle_cnt <= '0;
      sweep_img  <= '1;
      Col        <= 4'b1111;
    end else begin
      case (state)
        ST_SCAN: begin
          Col <= col_drive(col_idx);
          if (settle_cnt == SETTLE_TERM) begin
            sweep_img[{col_idx, 2'b00} +: 4] <= row_sync_p1;
            settle_cnt <= '0;
            if (col_idx == 2'd3) begin
              // Column 3 stays driven through EVAL.
              state <= ST_EVAL;
            end else begin
              col_idx <= col_idx + 2'd1;
              Col     <= col_drive(col_idx + 2'd1);
            end
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        default: begin
          state      <= ST_SCAN;
          col_idx    <= 2'd0;
          settle_cnt <= '0;
          Col        <= col_drive(2'd0);
        end
      endcase
    end
  end

  // Sweep classification: exactly one low bit is a key, none is idle, more is ghost.
  always_comb begin
    zero_cnt   = 5'd0;
    zero_pos   = 4'd0;
    cand       = CAND_NONE;
    cand_ghost = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!sweep_img[i]) begin
        zero_cnt = zero_cnt + 5'd1;
        zero_pos = 4'(i);
      end
    end
    if (zero_cnt == 5'd1) cand = {1'b0, key_map(zero_pos[3:2], zero_pos[1:0])};
    else if (zero_cnt != 5'd0) cand_ghost = 1'b1;
  end

  assign eval_vld = (state == ST_EVAL);

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
    .CNT_W         (CNT_W)
  ) u_debounce (
    .Clock     (Clock),
    .Reset     (Reset),
    .eval_vld  (eval_vld),
    .cand_ghost(cand_ghost),
    .cand      (cand),
    .held      (KeyHeld),
    .press_vld (press_vld),
    .press_code(press_code)
  );

  // CPU handshake: latch presses into KeyCode/KeyIrq, flag drops, clear on ack.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      KeyCode <= 4'h0;
      KeyIrq  <= 1'b0;
      Overrun <= 1'b0;
    end else if (press_vld) begin
      if (!KeyIrq) begin
        KeyCode <= press_code;
        KeyIrq  <= 1'b1;
      end else if (!IntAck) begin
        Overrun <= 1'b1;
      end else begin
        // Ack and new press coincide: hand over the new key immediately.
        KeyCode <= press_code;
        Overrun <= 1'b0;
      end
    end else if (IntAck && KeyIrq) begin
      KeyIrq  <= 1'b0;
      Overrun <= 1'b0;
    end
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Sequences a 4x4 matrix keypad: drives one active-low column at a time, waits a settle time, then samples the rows.
- Debounces the decoded key across full sweeps and turns each clean press into a single interrupt request toward the pipelined CPU.
- Holds the key code stable until the CPU acknowledges it.
- Replaces free-running per-clock scanning with a settle-timed, debounced, handshaked controller.

Parameters:
- SETTLE_CYCLES, 16: clocks each column is driven before Row is sampled (>=2).
- DEBOUNCE_SCANS, 4: consecutive identical full sweeps required to accept a press or a release (>=1).
- CNT_W, 8: width of the settle and debounce counters; must hold SETTLE_CYCLES-1 and DEBOUNCE_SCANS.

Ports:
- Clock, in, 1: sole clock, rising edge.
- Reset, in, 1: synchronous, active-high reset.
- Row, in, 4: keypad rows, active-low, asynchronous to Clock.
- Col, out, 4: keypad column drive, one-hot active-low.
- KeyCode, out, 4: code of the last accepted press.
- KeyIrq, out, 1: interrupt request; high while an unacknowledged key is pending.
- IntAck, in, 1: single-cycle CPU acknowledge.
- Overrun, out, 1: sticky flag; a press was dropped while KeyIrq was pending.
- KeyHeld, out, 1: debounced "key currently down" level.

Behaviour:
- Reset (Reset=1 at a clock edge): Col=4'b1111, KeyCode=0, KeyIrq=0, Overrun=0, KeyHeld=0, all counters 0, FSM=SCAN with column index 0. Reset applied mid-sweep or mid-handshake discards everything, including a pending key.
- Row is passed through a 2-flop synchronizer before any use.
- FSM SCAN:
  - Col = {1110, 1101, 1011, 0111} for column index 0..3.
  - The settle counter counts 0..SETTLE_CYCLES-1.
  - On the terminal count, capture the synchronized Row into that column's slot of a 16-bit sweep image, advance the index and clear the counter.
  - After column 3 is captured, go to EVAL (one cycle); Col stays at 0111 during EVAL.
- FSM EVAL:
  - Classify the sweep: exactly one zero bit in the whole image = single key; all ones = none; anything else = ghost/multi.
  - Then return to SCAN at column 0.
  - One sweep = 4*SETTLE_CYCLES + 1 clocks.
- Key map (column, row0..row3):
  - col0: 1, 4, 7, 0
  - col1: 2, 5, 8, F
  - col2: 3, 6, 9, E
  - col3: A, B, C, D
- Debounce, evaluated at EVAL only:
  - Candidate = single key code, or NONE. A ghost/multi sweep counts as a mismatch and resets the match count to 0.
  - The match count increments when the candidate equals the previous sweep's candidate; otherwise it becomes 1.
  - When the match count reaches DEBOUNCE_SCANS and the candidate differs from the debounced state, the debounced state updates. The count saturates.
  - NONE -> key X is a press event: KeyHeld=1.
  - Key X -> NONE is a release: KeyHeld=0, no event.
  - Key X -> key Y without an intervening NONE does not update the state and raises no event; a release is required first.
- Press event handling, registered in the cycle after EVAL:
  - KeyIrq=0: KeyCode<=X, KeyIrq<=1.
  - KeyIrq=1 and IntAck=0 in that cycle: new key dropped; KeyCode unchanged; Overrun<=1.
  - KeyIrq=1 and IntAck=1 in the same cycle: KeyCode<=X, KeyIrq stays 1, Overrun<=0.
- IntAck with no event: KeyIrq<=0 and Overrun<=0 next cycle; KeyCode retained. IntAck while KeyIrq=0 is ignored.
- Press latency: KeyIrq rises 2 clocks after the EVAL cycle of the DEBOUNCE_SCANS-th matching sweep (EVAL cycle, then the registered output).
- Counters never wrap past their terminal values.

Decomposition:
- Shared package keypad_pkg holds:
  - the column drive patterns;
  - the NONE encoding (5-bit candidate, with bit 4 as the none flag);
  - the key-map function (column index, row index) -> 4-bit code.
- The CPU interrupt logic reuses keypad_pkg.
- One natural sub-module: keypad_debounce, which takes the candidate per sweep and outputs the debounced state and a press pulse. The FSM, synchronizer and IRQ handshake stay in keypad_scan_ctrl.

Test Plan:
All scenarios use SETTLE_CYCLES=4 and DEBOUNCE_SCANS=2 (sweep = 17 clocks).
- Reset, then idle rows 4'b1111: Col cycles 1110, 1101, 1011, 0111, each held 4 clocks; KeyIrq=0, KeyHeld=0 indefinitely.
- Hold the key at col2/row3 (Row=0111 whenever Col=1011): after 2 sweeps, KeyIrq=1, KeyCode=4'hE, KeyHeld=1. IntAck pulse -> KeyIrq=0 next clock, KeyCode stays E.
- Press "5", release, then press "9" without acking: KeyCode stays 5, Overrun=1. IntAck -> KeyIrq=0, Overrun=0.
- Two keys down in the same column (Row=1100 at col0) for 5 sweeps: no event, KeyHeld=0.
- A one-sweep glitch on "1" followed by NONE: no event. Press "1" for 2 sweeps -> KeyCode=4'h1.
- Assert Reset during the 2nd debounce sweep of "A": all outputs return to reset values. After release of reset with the key still held, KeyIrq rises only after 2 fresh sweeps.
